// File: rtl/input_cond_pkg.sv
// Shared constants for the multiplier input conditioner: debounce default
// and the role of each pushbutton channel.
package input_cond_pkg;

    localparam int unsigned DB_CYCLES_DEFAULT = 500000;
    localparam int unsigned N_BTN_DEFAULT     = 3;
    localparam int unsigned SW_W_DEFAULT      = 8;

    localparam int unsigned BTN_EXECUTE = 0;
    localparam int unsigned BTN_CLRLD   = 1;
    localparam int unsigned BTN_RESET   = 2;

    // Qualification counter width; never below one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One pushbutton channel: 2-flop synchronizer, stability counter, debounced
// level and a single-cycle press pulse.
module debounce_channel
    import input_cond_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_raw,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DB_CYCLES - 1);

    logic             meta;
    logic             sync;
    logic             stable;
    logic             stable_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             press_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            meta   <= ~btn_n_raw;
            sync   <= meta;
            stable <= stable_nxt;
            cnt    <= cnt_nxt;
            press  <= press_nxt;
        end
    end

    // Any return of sync to stable clears the count: no partial credit.
    always_comb begin
        stable_nxt = stable;
        cnt_nxt    = '0;
        press_nxt  = 1'b0;
        if (sync != stable) begin
            if (cnt == CNT_TERM) begin
                stable_nxt = sync;
                press_nxt  = sync;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    assign level = stable;

endmodule

// File: rtl/input_conditioner.sv
// Board input conditioner: debounced buttons with press pulses and a
// synchronized multiplicand. Define INPUT_COND_SW_FREEZE_EN to latch mand
// only on ClearA_loadB presses.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int unsigned N_BTN     = N_BTN_DEFAULT,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int unsigned SW_W      = SW_W_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [N_BTN-1:0] btn_n_raw,
    input  logic [SW_W-1:0]  sw_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [SW_W-1:0]  mand
);

    logic [SW_W-1:0] sw_meta;
    logic [SW_W-1:0] sw_sync;

    for (genvar i = 0; i < int'(N_BTN); i++) begin : g_btn
        debounce_channel #(
            .DB_CYCLES(DB_CYCLES)
        ) u_chan (
            .clk      (Clk),
            .rst_n    (Reset_n),
            .btn_n_raw(btn_n_raw[i]),
            .level    (btn_level[i]),
            .press    (btn_press[i])
        );
    end

    // Switches are static operands: synchronize only, no debounce.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw_raw;
            sw_sync <= sw_meta;
        end
    end

`ifdef INPUT_COND_SW_FREEZE_EN
    logic [SW_W-1:0] mand_nxt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mand <= '0;
        end else begin
            mand <= mand_nxt;
        end
    end

    // Operand held constant for a whole multiply; reloaded on ClearA_loadB.
    always_comb begin
        mand_nxt = mand;
        if (btn_press[BTN_CLRLD]) begin
            mand_nxt = sw_sync;
        end
    end
`else
    assign mand = sw_sync;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with DB_CYCLES = 4: stimulus queues
// expected output snapshots, a monitor checks them whenever outputs change.
module tb_input_conditioner;

    logic       Clk;
    logic       Reset_n;
    logic [2:0] btn_n_raw;
    logic [7:0] sw_raw;
    logic [2:0] btn_level;
    logic [2:0] btn_press;
    logic [7:0] mand;

    typedef struct {
        int         cyc;
        logic [2:0] level;
        logic [2:0] press;
        logic [7:0] mand;
    } ev_t;

    ev_t        exp_q[$];
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    bit         mon_en = 1'b0;
    logic [13:0] prev = '0;

`ifdef INPUT_COND_SW_FREEZE_EN
    localparam logic [7:0] M_A = 8'h00;
    localparam logic [7:0] M_B = 8'h5A;
    localparam logic [7:0] M_C = 8'h00;
`else
    localparam logic [7:0] M_A = 8'h5A;
    localparam logic [7:0] M_B = 8'h11;
    localparam logic [7:0] M_C = 8'h11;
`endif

    input_conditioner #(
        .N_BTN    (3),
        .DB_CYCLES(4),
        .SW_W     (8)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .btn_n_raw(btn_n_raw),
        .sw_raw   (sw_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .mand     (mand)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int c, input logic [2:0] l, input logic [2:0] p, input logic [7:0] m);
        ev_t e;
        e.cyc   = c;
        e.level = l;
        e.press = p;
        e.mand  = m;
        exp_q.push_back(e);
    endtask

    // Monitor: every output change must match the next queued snapshot.
    always @(negedge Clk) begin
        logic [13:0] cur;
        ev_t e;
        if (mon_en) begin
            cur = {btn_level, btn_press, mand};
            if (cur != prev) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: cyc=%0d level=%b press=%b mand=%h, expected no change",
                             cyc, btn_level, btn_press, mand);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.level !== btn_level || e.press !== btn_press || e.mand !== mand) begin
                        n_fail++;
                        $display("FAIL output_event: cyc=%0d level=%b press=%b mand=%h, expected cyc=%0d level=%b press=%b mand=%h",
                                 cyc, btn_level, btn_press, mand, e.cyc, e.level, e.press, e.mand);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int k;
        Reset_n   = 1'b0;
        btn_n_raw = 3'b000;
        sw_raw    = 8'hFF;

        repeat (5) begin
            @(negedge Clk);
            check("reset_level", 32'(btn_level), 32'h0);
            check("reset_press", 32'(btn_press), 32'h0);
            check("reset_mand",  32'(mand),      32'h0);
        end
        btn_n_raw = 3'b111;
        sw_raw    = 8'h00;
        @(negedge Clk);
        Reset_n = 1'b1;
        prev    = '0;
        mon_en  = 1'b1;
        repeat (4) @(negedge Clk);

        // switches
        sw_raw = 8'h5A;
        k = cyc + 1;
`ifndef INPUT_COND_SW_FREEZE_EN
        push_ev(k + 1, 3'b000, 3'b000, 8'h5A);
`endif
        repeat (6) @(negedge Clk);

        // clean press and release on Execute
        btn_n_raw[0] = 1'b0;
        k = cyc + 1;
        push_ev(k + 5, 3'b001, 3'b001, M_A);
        push_ev(k + 6, 3'b001, 3'b000, M_A);
        repeat (20) @(negedge Clk);
        btn_n_raw[0] = 1'b1;
        k = cyc + 1;
        push_ev(k + 5, 3'b000, 3'b000, M_A);
        repeat (10) @(negedge Clk);

        // bouncing ClearA_loadB, then held
        for (int s = 0; s < 6; s++) begin
            btn_n_raw[1] = s[0];
            repeat (2) @(negedge Clk);
        end
        btn_n_raw[1] = 1'b0;
        k = cyc + 1;
        push_ev(k + 5, 3'b010, 3'b010, M_A);
        push_ev(k + 6, 3'b010, 3'b000, 8'h5A);
        repeat (12) @(negedge Clk);

        // new switch value: tracked, or ignored while frozen
        sw_raw = 8'h11;
        k = cyc + 1;
`ifndef INPUT_COND_SW_FREEZE_EN
        push_ev(k + 1, 3'b010, 3'b000, 8'h11);
`endif
        repeat (6) @(negedge Clk);

        // simultaneous presses on channels 0 and 2
        btn_n_raw = 3'b000;
        k = cyc + 1;
        push_ev(k + 5, 3'b111, 3'b101, M_B);
        push_ev(k + 6, 3'b111, 3'b000, M_B);
        repeat (12) @(negedge Clk);
        btn_n_raw = 3'b111;
        k = cyc + 1;
        push_ev(k + 5, 3'b000, 3'b000, M_B);
        repeat (10) @(negedge Clk);

        // reset in the middle of a qualification (cnt == 2)
        btn_n_raw[0] = 1'b0;
        repeat (4) @(negedge Clk);
        #2;
        mon_en  = 1'b0;
        Reset_n = 1'b0;
        #1;
        check("midrst_level", 32'(btn_level), 32'h0);
        check("midrst_press", 32'(btn_press), 32'h0);
        check("midrst_mand",  32'(mand),      32'h0);
        repeat (2) begin
            @(negedge Clk);
            check("midrst_hold_level", 32'(btn_level), 32'h0);
        end
        Reset_n = 1'b1;
        prev    = '0;
        mon_en  = 1'b1;
        k = cyc + 1;
`ifndef INPUT_COND_SW_FREEZE_EN
        push_ev(k + 1, 3'b000, 3'b000, 8'h11);
`endif
        push_ev(k + 5, 3'b001, 3'b001, M_C);
        push_ev(k + 6, 3'b001, 3'b000, M_C);
        repeat (12) @(negedge Clk);
        btn_n_raw[0] = 1'b1;
        k = cyc + 1;
        push_ev(k + 5, 3'b000, 3'b000, M_C);
        repeat (10) @(negedge Clk);

        check("final_mand", 32'(mand), 32'(M_C));
        check("pending_events", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
